// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STAT_EN is defined.
module dcache_ctrl #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
`ifdef DCACHE_STAT_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    input  logic [31:0] mem_din,
    input  logic        mem_ack
);

    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic                  wr_done;
    logic [31:0]           dout_q;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [31:0]           data [LINES][4];

    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [1:0]            word;
    logic                  hit;
    logic                  ack;
    logic                  ld_hit;
    logic                  miss_go;
    logic                  fill_we;
    logic                  wr_we;
    logic                  addr_unused;

    assign tag         = cpu_addr[31 -: TAG_BITS];
    assign index       = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign word        = cpu_addr[3:2];
    assign addr_unused = ^cpu_addr[1:0];

    assign hit     = valid[index] && (tags[index] == tag);
    assign ack     = mem_ack && mem_req;
    assign ld_hit  = (state == IDLE) && cpu_ren && !cpu_wen && hit;
    assign miss_go = (state == IDLE) && cpu_ren && !cpu_wen && !hit;
    assign fill_we = (state == REFILL) && ack;
    assign wr_we   = (state == WRITE) && ack && hit;

    assign cpu_dout = ld_hit ? data[index][word] : dout_q;

    // Stall: writes until acknowledged, misses until refilled and retried.
    always_comb begin
        cpu_stall = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (cpu_wen)
                        cpu_stall = !wr_done;
                    else if (cpu_ren)
                        cpu_stall = !hit;
                end
                default: cpu_stall = 1'b1;
            endcase
        end
    end

    // Line storage: refill beats, tag install and write-through hit update.
    always_ff @(posedge clk) begin
        if (fill_we)
            data[index][cnt] <= mem_din;
        if (fill_we && cnt == 2'd3)
            tags[index] <= tag;
        if (wr_we)
            data[index][word] <= cpu_din;
    end

    // Controller FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            wr_done  <= 1'b0;
            dout_q   <= 32'd0;
            valid    <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 32'd0;
            mem_dout <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    wr_done <= 1'b0;
                    if (cpu_wen && !wr_done) begin
                        state    <= WRITE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= {cpu_addr[31:2], 2'b00};
                        mem_dout <= cpu_din;
                    end else if (miss_go) begin
                        state    <= REFILL;
                        cnt      <= 2'd0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {tag, index, 4'b0000};
                    end else if (ld_hit) begin
                        dout_q <= data[index][word];
                    end
                end
                REFILL: begin
                    if (ack) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid[index] <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            mem_addr <= {tag, index, cnt + 2'd1, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        wr_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STAT_EN
    // Saturating hit/miss counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
        end else begin
            if (ld_hit && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (miss_go && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: transaction vector table plus
// reset-during-refill and reset-state sequences.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_din = 32'd0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din = 32'd0;
    logic        mem_ack = 1'b0;
`ifdef DCACHE_STAT_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int tests = 0;
    int fails = 0;

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
`ifdef DCACHE_STAT_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .mem_din   (mem_din),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // Main memory model.
    logic [31:0] model [logic [31:0]];
    int          ack_lat = 1;
    int          wcnt = 0;
    int          beats = 0;
    logic [31:0] last_addr = 32'd0;
    logic        last_we = 1'b0;
    logic [31:0] beat_q [$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (model.exists(a))
            return model[a];
        if (a >= 32'h100 && a <= 32'h10C)
            return 32'hA0 + {28'd0, a[5:2]} - 32'd0;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Responder: acks each request after ack_lat cycles of mem_req.
    always @(negedge clk) begin
        if (rst && mem_req) begin
            if (pend)
                chk("req_hold_addr", mem_addr, pend_addr);
            if (wcnt == ack_lat - 1) begin
                mem_ack = 1'b1;
                if (mem_we)
                    model[mem_addr] = mem_dout;
                else
                    mem_din = rd(mem_addr);
                beats++;
                last_addr = mem_addr;
                last_we = mem_we;
                beat_q.push_back(mem_addr);
                wcnt = 0;
                pend = 1'b0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
                pend = 1'b1;
                pend_addr = mem_addr;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
            pend = 1'b0;
        end
    end

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] din;
        int          lat;
        int          stalls;
        int          nbeats;
        logic [31:0] dout;
        logic [31:0] laddr;
        logic        lwe;
    } vec_t;

    vec_t vecs [8];

    task automatic access(input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] din,
                          output int stalls, output logic [31:0] dout);
        @(negedge clk);
        cpu_ren = ren;
        cpu_wen = wen;
        cpu_addr = addr;
        cpu_din = din;
        stalls = 0;
        dout = 32'hX;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!cpu_stall) begin
                dout = cpu_dout;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(negedge clk);
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
    endtask

    initial begin
        int st;
        logic [31:0] d;

        vecs[0] = '{1, 0, 32'h0000_0104, 0, 1, 5, 4, 32'hA1, 32'h10C, 0};
        vecs[1] = '{1, 0, 32'h0000_0108, 0, 1, 0, 0, 32'hA2, 32'h10C, 0};
        vecs[2] = '{0, 1, 32'h0000_0104, 32'hDEAD_BEEF, 3, 4, 1, 0,
                    32'h104, 1};
        vecs[3] = '{1, 0, 32'h0000_0104, 0, 1, 0, 0, 32'hDEAD_BEEF,
                    32'h104, 1};
        vecs[4] = '{0, 1, 32'h2000_0104, 32'h1234_5678, 1, 2, 1, 0,
                    32'h2000_0104, 1};
        vecs[5] = '{1, 0, 32'h0000_0104, 0, 1, 0, 0, 32'hDEAD_BEEF,
                    32'h2000_0104, 1};
        vecs[6] = '{1, 0, 32'h2000_0104, 0, 2, 9, 4, 32'h1234_5678,
                    32'h2000_010C, 0};
        vecs[7] = '{1, 0, 32'h0000_0104, 0, 1, 5, 4, 32'hDEAD_BEEF,
                    32'h10C, 0};

        #2 rst = 1'b0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_dout", mem_dout, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_dout", cpu_dout, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ack_lat = vecs[i].lat;
            beats = 0;
            beat_q.delete();
            access(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].din,
                   st, d);
            chk($sformatf("v%0d_stalls", i), st, vecs[i].stalls);
            chk($sformatf("v%0d_beats", i), beats, vecs[i].nbeats);
            if (vecs[i].ren)
                chk($sformatf("v%0d_dout", i), d, vecs[i].dout);
            if (vecs[i].nbeats != 0) begin
                chk($sformatf("v%0d_laddr", i), last_addr, vecs[i].laddr);
                chk($sformatf("v%0d_lwe", i), {31'd0, last_we},
                    {31'd0, vecs[i].lwe});
            end
            if (i == 0 && beat_q.size() == 4) begin
                for (int b = 0; b < 4; b++)
                    chk($sformatf("beat%0d_addr", b), beat_q[b],
                        32'h100 + 32'(b * 4));
            end
`ifdef DCACHE_STAT_EN
            if (i == 1) begin
                chk("stat_misses", stat_misses, 32'd1);
                chk("stat_hits", stat_hits, 32'd2);
            end
`endif
        end

        // Reset asserted after the second refill beat of a miss at 0x300.
        ack_lat = 1;
        beats = 0;
        @(negedge clk);
        cpu_ren = 1'b1;
        cpu_addr = 32'h0000_0300;
        begin
            int k;
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
                if (beats == 2)
                    break;
            end
            chk("rst_wait_2beats", beats, 2);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_ren = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        beats = 0;
        access(1'b1, 1'b0, 32'h0000_0300, 32'd0, st, d);
        chk("re300_stalls", st, 5);
        chk("re300_beats", beats, 4);
        chk("re300_dout", d, 32'h5A5A_0300);
        beats = 0;
        access(1'b1, 1'b0, 32'h0000_0104, 32'd0, st, d);
        chk("post_rst_miss_beats", beats, 4);
        chk("post_rst_dout", d, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the pipeline core's data-memory port (ren/wen/addr/dout/din) and the slower main data memory.
- Stalls the core on misses and on every write until main memory acknowledges.
- Lines are 4 words; refill is a 4-beat sequential fill over a req/ack handshake.

Parameters:
- INDEX_BITS, 6, line index width (2^INDEX_BITS lines).
- OFFSET_BITS, 4, byte offset within a line (fixed: 4 words x 4 bytes).
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS, tag width (derived; not overridden).

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cpu_ren  in  1  core load request.
- cpu_wen  in  1  core store request.
- cpu_addr  in  32  byte address, word aligned; [1:0] ignored.
- cpu_din  in  32  store data from core.
- cpu_dout  out  32  load data to core.
- cpu_stall  out  1  core must hold the request and freeze the pipeline.
- mem_req  out  1  main memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned main memory address.
- mem_dout  out  32  write data to memory.
- mem_din  in  32  read data from memory.
- mem_ack  in  1  one-cycle completion pulse; sampled only while mem_req=1.

Behaviour:
- Address split: tag = [31:31-TAG_BITS+1], index = [OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], word = [3:2].
- Storage: valid bit per line (reset to 0); tag and data arrays are not reset.
- Reset (rst=0, async):
  - All valid bits cleared; FSM = IDLE; refill counter = 0; wr_done = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_dout = 0, cpu_stall = 0, cpu_dout = 0.
  - Reset mid-refill or mid-write abandons the transaction; the line is left invalid.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - hit = valid[index] && tag match.
  - cpu_wen=1 and wr_done=0: go to WRITE; cpu_stall=1 combinationally. cpu_wen has priority when cpu_ren=1 in the same cycle.
  - cpu_ren=1 and hit: cpu_dout = data[index][word] combinationally; cpu_stall=0; zero-cycle latency.
  - cpu_ren=1 and miss: cpu_stall=1; go to REFILL with counter=0.
  - wr_done=1: cpu_stall=0 for exactly this cycle; wr_done clears on the next edge.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}.
  - Each mem_ack: data[index][counter] <= mem_din; counter++.
  - On the 4th ack: tag written, valid set, return to IDLE. The retried load then hits, so total miss penalty = 4 handshakes + 1 cycle.
  - cpu_stall=1 throughout.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = {cpu_addr[31:2], 2'b00}, mem_dout = cpu_din.
  - On mem_ack: if hit, data[index][word] <= cpu_din (tag/valid unchanged); on miss there is no allocation. Set wr_done=1; return to IDLE.
  - cpu_stall=1 throughout.
- Handshake: mem_req and mem_addr/mem_we/mem_dout are registered and held stable from assertion until the ack cycle. mem_req drops the cycle after ack unless the next beat follows immediately. mem_ack while mem_req=0 is ignored.
- Counter wraps 3 -> 0 only on the final beat.
- Reads with cpu_ren=0 and cpu_wen=0: no state change; cpu_dout holds its last value.

Optional Feature:
- DCACHE_STAT_EN defined:
  - Adds output ports stat_hits[31:0] and stat_misses[31:0]; both reset to 0.
  - stat_hits increments on each IDLE load hit with cpu_stall=0. A retried load after refill also counts as a hit.
  - stat_misses increments on each IDLE -> REFILL transition.
  - Both saturate at 32'hFFFF_FFFF.
- DCACHE_STAT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load 0x0000_0104; memory returns 0xA0..0xA3 for words 0x100..0x10C -> four read beats at 0x100, 0x104, 0x108, 0x10C; cpu_dout=0xA1 with stall low on the cycle after the 4th ack.
- Load 0x0000_0108 immediately after that -> hit, stall=0, cpu_dout=0xA2, mem_req stays 0.
- Store 0xDEAD_BEEF to 0x104 (hit) with mem_ack after 3 cycles -> stall high 4 cycles, mem_we=1 at addr 0x104; a following load of 0x104 returns 0xDEAD_BEEF with no refill.
- Store to 0x2000_0104 (same index, different tag) -> memory write only; a following load of 0x104 still hits with 0xDEAD_BEEF.
- Assert rst=0 after the 2nd refill ack of a miss at 0x300 -> mem_req=0 immediately; a later load of 0x300 performs a full 4-beat refill again.
- With DCACHE_STAT_EN: previous sequence from reset -> stat_misses=1 and stat_hits=2 after the first two scenarios.
